// File: rtl/unsigned_multiplier.sv
// unsigned_multiplier: registered unsigned a*b built from an AND array, carry-save rows and a ripple adder
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset, clears product
//   a, b    WIDTH-bit unsigned operands
//   product 2*WIDTH-bit registered product, one cycle after a/b are sampled
module unsigned_multiplier #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] product
);
   localparam int PW = 2 * WIDTH;
   logic [PW-1:0] s, c, p, t, r;
   logic          cy;
   // s/c hold the running sum in carry-save form; each row folds in one shifted partial product.
   // Carries out of the top bit are always zero because the true product fits in PW bits.
   always_comb begin
      s  = '0;
      c  = '0;
      p  = '0;
      t  = '0;
      r  = '0;
      cy = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         p = {{WIDTH{1'b0}}, a & {WIDTH{b[i]}}} << i;
         t = (s & c) | (s & p) | (c & p);
         s = s ^ c ^ p;
         c = t << 1;
      end
      for (int k = 0; k < PW; k++) begin
         r[k] = s[k] ^ c[k] ^ cy;
         cy   = (s[k] & c[k]) | (s[k] & cy) | (c[k] & cy);
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) product <= '0;
      else        product <= r;
endmodule

// File: tb/tb_unsigned_multiplier.sv
// tb_unsigned_multiplier: random, directed and exhaustive checks of unsigned_multiplier against a*b
module tb_unsigned_multiplier;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [7:0]  a = 8'hFF, b = 8'hFF;
   logic [15:0] product;
   logic [15:0] exp_p = 16'h0;
   int          pass = 0, total = 0;

   unsigned_multiplier #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .product(product));

   always #5 clk = ~clk;

   // expected value: the integer product of the operands seen at the last edge, 0 under reset
   always @(posedge clk or negedge rst_n)
      if (!rst_n) exp_p = 16'h0;
      else exp_p = 16'(int'(a) * int'(b));

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
      total++;
      if (got === want) pass++;
      else $display("FAIL %s: product=%0d expected=%0d", name, got, want);
   endtask

   always @(negedge clk) chk("model", product, exp_p);

   task automatic apply(input logic [7:0] x, input logic [7:0] y);
      a = x;
      b = y;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #1 chk("reset_async", product, 16'h0);
      repeat (4) begin
         @(posedge clk);
         #1 chk("reset_hold", product, 16'h0);
      end
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1 chk("ff_ff", product, 16'hFE01);
      apply(8'd0, 8'd200);   chk("zero", product, 16'd0);
      apply(8'd1, 8'd173);   chk("ident_a1", product, 16'd173);
      apply(8'd97, 8'd1);    chk("ident_b1", product, 16'd97);
      apply(8'd36, 8'd129);  chk("b2b_0", product, 16'd4644);
      apply(8'd9, 8'd99);    chk("b2b_1", product, 16'd891);
      apply(8'd13, 8'd141);  chk("b2b_2", product, 16'd1833);
      apply(8'd255, 8'd0);   chk("zero_b", product, 16'd0);
      repeat (20) apply(8'($urandom), 8'($urandom));
      apply(8'd36, 8'd129);  chk("pre_rst", product, 16'd4644);
      #3 rst_n = 1'b0;
      #1 chk("rst_mid", product, 16'd0);
      a = 8'd5;
      b = 8'd7;
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1 chk("post_rst", product, 16'd35);
      for (int i = 0; i < 256; i++)
         for (int j = 0; j < 256; j++)
            apply(8'(i), 8'(j));
      @(negedge clk);
      #1 $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
